// File: rtl/mc_datapath_p_if.sv
// Bundle between the multicycle controller/memory (master) and the datapath (slave):
// per-cycle controls and memory read data in, decode fields, status and memory bus out.
interface mc_datapath_p_if #(
    parameter int WIDTH = 32
);
    logic             pcen;
    logic             irwrite;
    logic             regwrite;
    logic             alusrca;
    logic             iord;
    logic             memtoreg;
    logic             regdst;
    logic [1:0]       alusrcb;
    logic [1:0]       pcsrc;
    logic [2:0]       alucontrol;
    logic             memready;
    logic [WIDTH-1:0] readdata;
    logic [5:0]       op;
    logic [5:0]       funct;
    logic             zero;
    logic [WIDTH-1:0] adr;
    logic [WIDTH-1:0] writedata;

    modport master (
        output pcen, irwrite, regwrite, alusrca, iord, memtoreg, regdst,
               alusrcb, pcsrc, alucontrol, memready, readdata,
        input  op, funct, zero, adr, writedata
    );

    modport slave (
        input  pcen, irwrite, regwrite, alusrca, iord, memtoreg, regdst,
               alusrcb, pcsrc, alucontrol, memready, readdata,
        output op, funct, zero, adr, writedata
    );
endinterface

// File: rtl/mc_datapath_p.sv
// Parametrised multicycle MIPS-style datapath: PC, IR, data/A/B/ALUOut registers,
// register file and ALU, stepped one controller state per clock with a memory-ready freeze.
module mc_datapath_p #(
    parameter int               WIDTH    = 32,
    parameter int               NREGS    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic           clk,
    input  logic           reset,
    mc_datapath_p_if.slave bus
);
    localparam int RBITS = $clog2(NREGS);

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } aluOp_e;

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [31:0]      ir_q, ir_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] aluOut_q, aluOut_d;
    logic [WIDTH-1:0] rf_q [NREGS];

    logic [RBITS-1:0] rsIdx, rtIdx, rdIdx, writeReg;
    logic [WIDTH-1:0] rd1, rd2, wd3;
    logic [WIDTH-1:0] signImm, signImmSh, srcA, srcB;
    logic [WIDTH-1:0] aluResult, jumpTarget, pcNext;
    logic             rfWe;

    // Register indices are the low bits of the 5-bit fields; index 0 is hard-wired to zero.
    assign rsIdx    = ir_q[21 +: RBITS];
    assign rtIdx    = ir_q[16 +: RBITS];
    assign rdIdx    = ir_q[11 +: RBITS];
    assign writeReg = bus.regdst ? rdIdx : rtIdx;
    assign rd1      = (rsIdx == '0) ? '0 : rf_q[rsIdx];
    assign rd2      = (rtIdx == '0) ? '0 : rf_q[rtIdx];
    assign wd3      = bus.memtoreg ? data_q : aluOut_q;
    assign rfWe     = bus.memready && bus.regwrite && (writeReg != '0);

    assign signImm    = {{(WIDTH-16){ir_q[15]}}, ir_q[15:0]};
    assign signImmSh  = {signImm[WIDTH-3:0], 2'b00};
    assign jumpTarget = {pc_q[WIDTH-1:28], ir_q[25:0], 2'b00};
    assign srcA       = bus.alusrca ? a_q : pc_q;

    always_comb begin
        srcB = b_q;
        case (bus.alusrcb)
            2'b00:   srcB = b_q;
            2'b01:   srcB = {{(WIDTH-3){1'b0}}, 3'b100};
            2'b10:   srcB = signImm;
            default: srcB = signImmSh;
        endcase
    end

    // Unlisted opcodes deliberately yield zero so an unexpected encoding is harmless.
    always_comb begin
        aluResult = '0;
        case (bus.alucontrol)
            ALU_AND: aluResult = srcA & srcB;
            ALU_OR:  aluResult = srcA | srcB;
            ALU_ADD: aluResult = srcA + srcB;
            ALU_SUB: aluResult = srcA - srcB;
            ALU_SLT: aluResult = {{(WIDTH-1){1'b0}}, ($signed(srcA) < $signed(srcB))};
            default: aluResult = '0;
        endcase
    end

    always_comb begin
        pcNext = pc_q;
        case (bus.pcsrc)
            2'b00:   pcNext = aluResult;
            2'b01:   pcNext = aluOut_q;
            2'b10:   pcNext = jumpTarget;
            default: pcNext = pc_q;
        endcase
    end

    always_comb begin
        pc_d     = pc_q;
        ir_d     = ir_q;
        data_d   = data_q;
        a_d      = a_q;
        b_d      = b_q;
        aluOut_d = aluOut_q;
        if (bus.memready) begin
            if (bus.pcen) begin
                pc_d = pcNext;
            end
            if (bus.irwrite) begin
                ir_d = bus.readdata[31:0];
            end
            data_d   = bus.readdata;
            a_d      = rd1;
            b_d      = rd2;
            aluOut_d = aluResult;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            data_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            aluOut_q <= '0;
        end else begin
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            data_q   <= data_d;
            a_q      <= a_d;
            b_q      <= b_d;
            aluOut_q <= aluOut_d;
        end
    end

    // A/B sample the combinational read ports, so a same-edge write is seen one cycle later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
        end else if (rfWe) begin
            rf_q[writeReg] <= wd3;
        end
    end

    assign bus.op        = ir_q[31:26];
    assign bus.funct     = ir_q[5:0];
    assign bus.zero      = (aluResult == '0);
    assign bus.adr       = bus.iord ? aluOut_q : pc_q;
    assign bus.writedata = b_q;
endmodule

// File: doc/mc_datapath_p.md
Name: mc_datapath_p

Overview:
- Parametrised multicycle MIPS-style datapath for the next-generation core.
- Holds PC, instruction register (IR), memory-data register, A/B operand registers, ALUOut register, register file and ALU.
- Driven cycle-by-cycle by the existing multicycle controller. Adds configurable data width, register count and reset vector, a jump PC source, and a memory-ready freeze.

Parameters:
- WIDTH, 32, data/address width in bits (>=32); instruction word stays 32 bits.
- NREGS, 32, register-file entries (power of two, 2..32); register index = low $clog2(NREGS) bits of the 5-bit instruction field.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- pcen  in  1  PC write enable.
- irwrite  in  1  IR write enable.
- regwrite  in  1  register-file write enable.
- alusrca  in  1  ALU A source: 0 = PC, 1 = A register.
- iord  in  1  address source: 0 = PC, 1 = ALUOut.
- memtoreg  in  1  register write data: 0 = ALUOut, 1 = data register.
- regdst  in  1  destination register: 0 = rt instr[20:16], 1 = rd instr[15:11].
- alusrcb  in  2  ALU B source: 00 = B, 01 = constant 4, 10 = signimm, 11 = signimm<<2.
- pcsrc  in  2  next PC: 00 = aluresult, 01 = ALUOut, 10 = jump target, 11 = hold PC.
- alucontrol  in  3  ALU operation.
- memready  in  1  memory ready; 0 freezes all state.
- readdata  in  WIDTH  memory read data.
- op  out  6  IR[31:26].
- funct  out  6  IR[5:0].
- zero  out  1  aluresult == 0 (combinational).
- adr  out  WIDTH  memory address.
- writedata  out  WIDTH  memory write data (= B register).

Behaviour:
- Reset (reset==0, async): PC=RESET_PC; IR, data, A, B, ALUOut = 0; all register-file entries = 0. Consequently op=0, funct=0, writedata=0, adr=RESET_PC when iord=0.
- Freeze: when memready==0, no state element changes (PC, IR, data, A, B, ALUOut, register file), regardless of enables. Combinational outputs still track current state and controls.
- With memready==1, on each rising edge:
  - PC <= pcnext if pcen.
  - IR <= readdata[31:0] if irwrite.
  - data <= readdata unconditionally.
  - A <= rf[rs] and B <= rf[rt] unconditionally.
  - ALUOut <= aluresult unconditionally.
  - rf[writereg] <= wd3 if regwrite.
- Register file:
  - Register 0 reads as 0 always; writes to it are discarded.
  - Reads are combinational.
  - A/B capture the pre-write value when a read and a write of the same register land on the same edge. The new value is visible one cycle later.
- signimm: IR[15:0] sign-extended to WIDTH. signimmsh = signimm<<2, truncated to WIDTH.
- Jump target: {PC[WIDTH-1:28], IR[25:0], 2'b00}.
- pcsrc=11 holds PC even when pcen=1.
- ALU (WIDTH bits, wrap-around, no overflow flag):
  - 010 add.
  - 110 subtract.
  - 000 AND.
  - 001 OR.
  - 111 set-less-than, signed: result 1 or 0, zero-extended.
  - 011/100/101 produce result 0.
- adr = iord ? ALUOut : PC. writedata = B.
- zero is purely combinational from the current aluresult, with no latency.
- Reset asserted mid-instruction: all state clears immediately; no pending register-file write completes.

Test Plan:
- Reset with RESET_PC=32'h0040_0000, reset=0 then 1 -> adr=0x00400000, op=0, funct=0, writedata=0, all rf entries read 0.
- Fetch: readdata=0x8C080004 (lw $t0,4($0)), iord=0, irwrite=1, alusrca=0, alusrcb=01, alucontrol=010, pcsrc=00, pcen=1, memready=1, one edge -> op=0x23, PC=0x00400004.
- Freeze: repeat the fetch with memready=0 for 3 cycles -> PC, IR and ALUOut unchanged. Raise memready -> update occurs on the next edge only.
- R-type add: preload rf[9]=5 and rf[10]=-7, IR=add $8,$9,$10. Clock A/B, then alusrca=1, alusrcb=00, alucontrol=010, then regdst=1, regwrite=1, memtoreg=0 -> rf[8]=0xFFFFFFFE. Writing $0 leaves it reading 0.
- Branch/slt: A=3, B=3, alucontrol=110 -> zero=1. A=-1, B=1, alucontrol=111 -> aluresult=1. signimm=0xFFFF with alusrcb=11 -> srcb=0xFFFFFFFC.
- Jump and width: WIDTH=64, PC=0x0000_0000_1000_0008, IR=0x08000010, pcsrc=10, pcen=1 -> PC=0x0000_0000_1000_0040. Then pcsrc=11, pcen=1 -> PC unchanged.
